mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the 128x8 single-port RAM block.
- Port 0 is the instruction-fetch requester; port 1 is the data load/store requester.
- Grants one port at a time (round-robin) and drives the RAM's en/read/write/address/data pins.
- Waits for the RAM ready handshake, returns read data with a one-cycle ack, and drops en for one cycle between transactions so the RAM's internal ready counter resets.

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle joining the two requesters (fetch port 0, load/store port 1),
// the arbiter and the 128x8 single-port RAM.
interface mem_arbiter_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic              err0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic              err1;
   logic [DATA_W-1:0] rdata1;

   logic              mem_en;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   // Arbiter side: consumes requests and RAM responses, drives acks and RAM pins.
   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_rdata, mem_ready,
      output ack0, err0, rdata0,
      output ack1, err1, rdata1,
      output mem_en, mem_read, mem_write, mem_address, mem_wdata
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_rdata, mem_ready,
      input  ack0, err0, rdata0,
      input  ack1, err1, rdata1,
      input  mem_en, mem_read, mem_write, mem_address, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter/sequencer for the 128x8 single-port RAM.
// IDLE grants and launches an access, ACCESS waits for ready or timeout, RELEASE drops en.
module mem_arbiter #(
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              rr_q, rr_d;
   logic              gnt_q, gnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              en_q, en_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              err0_q, err0_d;
   logic              err1_q, err1_d;
   logic              sel;

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      gnt_d    = gnt_q;
      cnt_d    = cnt_q;
      en_d     = en_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      err0_d   = 1'b0;
      err1_d   = 1'b0;
      sel      = rr_q;

      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // rr_q only advances when both ports contend.
               if (bus.req0 && bus.req1) begin
                  sel  = rr_q;
                  rr_d = ~rr_q;
               end else begin
                  sel  = bus.req1;
               end
               gnt_d = sel;
               if (sel) begin
                  wr_d    = bus.we1;
                  addr_d  = bus.addr1;
                  wdata_d = bus.wdata1;
               end else begin
                  wr_d    = bus.we0;
                  addr_d  = bus.addr0;
                  wdata_d = bus.wdata0;
               end
               rd_d    = ~wr_d;
               en_d    = 1'b1;
               cnt_d   = '0;
               state_d = ACCESS;
            end
         end

         ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.mem_ready) begin
               if (rd_q) begin
                  if (gnt_q) rdata1_d = bus.mem_rdata;
                  else       rdata0_d = bus.mem_rdata;
               end
               ack0_d  = ~gnt_q;
               ack1_d  = gnt_q;
               en_d    = 1'b0;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = RELEASE;
            end else if (cnt_d == TO_CNT) begin
               ack0_d  = ~gnt_q;
               ack1_d  = gnt_q;
               err0_d  = ~gnt_q;
               err1_d  = gnt_q;
               en_d    = 1'b0;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = RELEASE;
            end
         end

         // en stays low here for one cycle so the RAM's ready counter restarts.
         RELEASE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_q     <= 1'b0;
         gnt_q    <= 1'b0;
         cnt_q    <= '0;
         en_q     <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         gnt_q    <= gnt_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
      end
   end

   assign bus.mem_en      = en_q;
   assign bus.mem_read    = rd_q;
   assign bus.mem_write   = wr_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.ack0        = ack0_q;
   assign bus.ack1        = ack1_q;
   assign bus.err0        = err0_q;
   assign bus.err1        = err1_q;
   assign bus.rdata0      = rdata0_q;
   assign bus.rdata1      = rdata1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, transaction-level reference model
// (shadow memory + round-robin rule) and directed plus randomized batches.
module tb_mem_arbiter;
   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 15;

   typedef struct packed {
      logic       we;
      logic [6:0] addr;
      logic [7:0] data;
   } txn_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int         passes = 0;
   int         fails  = 0;
   int         total  = 0;
   logic [7:0] shadow [128];
   logic [7:0] last_rd [2];
   bit         rr_m   = 1'b0;
   bit         stub   = 1'b0;
   txn_t       q0 [$];
   txn_t       q1 [$];

   function automatic logic [7:0] init_val(int i);
      if (i == 5) return 8'hA5;
      return 8'((i * 29) ^ 90);
   endfunction

   // Behavioural RAM: count restarts while en is low, ready one edge after count reaches 1.
   logic [7:0] ram [128];
   bit         loaded  = 1'b0;
   int         ram_cnt = 0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
         loaded <= 1'b1;
      end
      if (!bus.mem_en) begin
         ram_cnt       <= 0;
         bus.mem_ready <= 1'b0;
      end else begin
         ram_cnt <= ram_cnt + 1;
         if (ram_cnt >= 1 && !stub) begin
            bus.mem_ready <= 1'b1;
            if (bus.mem_write) ram[bus.mem_address] <= bus.mem_wdata;
            else               bus.mem_rdata <= ram[bus.mem_address];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("rd_wr_exclusive", 32'(bus.mem_read & bus.mem_write), 0);
         check("ack_exclusive", 32'(bus.ack0 & bus.ack1), 0);
      end
   end

   task automatic drive();
      bus.req0 = (q0.size() > 0);
      if (q0.size() > 0) begin
         bus.we0 = q0[0].we; bus.addr0 = q0[0].addr; bus.wdata0 = q0[0].data;
      end
      bus.req1 = (q1.size() > 0);
      if (q1.size() > 0) begin
         bus.we1 = q1[0].we; bus.addr1 = q1[0].addr; bus.wdata1 = q1[0].data;
      end
   endtask

   task automatic idle(input int n);
      int busy = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (bus.mem_en || bus.ack0 || bus.ack1) busy++;
      end
      check("idle_quiet", busy, 0);
   endtask

   // Serve everything in q0/q1; each requester presents its next item right after its ack.
   task automatic run_batch(input bit drop0);
      txn_t       c0 [$];
      txn_t       c1 [$];
      txn_t       t;
      int         exp_p [$];
      txn_t       exp_t [$];
      logic [7:0] exp_rd [$];
      int         n, a, g, lat, budget, gcyc, last_ack;
      bit         p, prev_en;
      c0 = q0;
      c1 = q1;
      while (c0.size() > 0 || c1.size() > 0) begin
         if (c0.size() > 0 && c1.size() > 0) begin
            p    = rr_m;
            rr_m = ~rr_m;
         end else begin
            p = (c1.size() > 0);
         end
         if (p) t = c1.pop_front();
         else   t = c0.pop_front();
         if (!stub) begin
            if (t.we) shadow[t.addr] = t.data;
            else      last_rd[p] = shadow[t.addr];
         end
         exp_p.push_back(int'(p));
         exp_t.push_back(t);
         exp_rd.push_back(last_rd[p]);
      end
      n        = exp_p.size();
      lat      = stub ? TIMEOUT : 3;
      budget   = n * (lat + 3) + 10;
      a        = 0;
      g        = 0;
      gcyc     = 0;
      last_ack = -100;
      prev_en  = bus.mem_en;
      drive();
      for (int c = 0; c < budget && a < n; c++) begin
         @(negedge clk);
         if (bus.mem_en && !prev_en) begin
            if (g < n) begin
               check("grant_addr", 32'(bus.mem_address), 32'(exp_t[g].addr));
               check("grant_write", 32'(bus.mem_write), 32'(exp_t[g].we));
               check("grant_read", 32'(bus.mem_read), 32'(!exp_t[g].we));
               check("grant_wdata", 32'(bus.mem_wdata), 32'(exp_t[g].data));
               if (g > 0) check("ack_to_grant_gap", c - last_ack, 2);
            end else begin
               check("extra_grant", g, n);
            end
            gcyc = c;
            g++;
            if (drop0) begin
               bus.req0   = 1'b0;
               bus.addr0  = ~bus.addr0;
               bus.wdata0 = ~bus.wdata0;
            end
         end
         if (bus.ack0 || bus.ack1) begin
            p = bus.ack1;
            check("ack_port", 32'(p), exp_p[a]);
            check("ack_latency", c - gcyc, lat);
            check("ack_err", 32'(p ? bus.err1 : bus.err0), 32'(stub));
            check("ack_rdata", 32'(p ? bus.rdata1 : bus.rdata0), 32'(exp_rd[a]));
            check("ack_mem_en_low", 32'(bus.mem_en), 0);
            last_ack = c;
            a++;
            if (p) void'(q1.pop_front());
            else   void'(q0.pop_front());
            drive();
         end
         prev_en = bus.mem_en;
      end
      check("batch_done", a, n);
   endtask

   initial begin
      int   seen;
      int   n0, n1;
      txn_t t;
      bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
      for (int i = 0; i < 128; i++) shadow[i] = init_val(i);
      last_rd[0] = '0;
      last_rd[1] = '0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_mem_en", 32'(bus.mem_en), 0);
      check("rst_mem_read", 32'(bus.mem_read), 0);
      check("rst_mem_write", 32'(bus.mem_write), 0);
      check("rst_mem_address", 32'(bus.mem_address), 0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
      check("rst_ack", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 0);
      check("rst_rdata0", 32'(bus.rdata0), 0);
      check("rst_rdata1", 32'(bus.rdata1), 0);
      rst_n = 1'b1;
      idle(2);

      // Port 0 read of the preloaded location
      q0.push_back('{we: 1'b0, addr: 7'h05, data: 8'h00});
      run_batch(1'b0);
      idle(3);
      check("rdata0_hold", 32'(bus.rdata0), 32'h0A5);

      // Port 1 write then read back
      q1.push_back('{we: 1'b1, addr: 7'h10, data: 8'h3C});
      q1.push_back('{we: 1'b0, addr: 7'h10, data: 8'h77});
      run_batch(1'b0);
      check("rdata1_readback", 32'(bus.rdata1), 32'h03C);

      // Both ports held busy: grants alternate
      for (int i = 0; i < 2; i++) begin
         q0.push_back('{we: 1'b0, addr: 7'(i + 1), data: 8'h00});
         q1.push_back('{we: 1'b0, addr: 7'(i + 8), data: 8'h00});
      end
      run_batch(1'b0);

      // RAM never ready: timeout with err, rdata0 untouched, then a normal access
      stub = 1'b1;
      q0.push_back('{we: 1'b0, addr: 7'h22, data: 8'h00});
      run_batch(1'b0);
      stub = 1'b0;
      q1.push_back('{we: 1'b0, addr: 7'h05, data: 8'h00});
      run_batch(1'b0);

      // Requester abandons req and scrambles its fields right after the grant
      q0.push_back('{we: 1'b0, addr: 7'h05, data: 8'h11});
      run_batch(1'b1);
      idle(6);

      // Randomized batches
      for (int b = 0; b < 10; b++) begin
         n0 = $urandom_range(0, 3);
         n1 = $urandom_range(0, 3);
         if (n0 + n1 == 0) n0 = 1;
         for (int i = 0; i < n0 + n1; i++) begin
            t.we   = 1'($urandom_range(0, 1));
            t.addr = 7'($urandom_range(0, 15));
            t.data = 8'($urandom);
            if (i < n0) q0.push_back(t);
            else        q1.push_back(t);
         end
         run_batch(1'b0);
      end

      // Leave rr favouring port 1, then reset in the middle of an access
      if (!rr_m) begin
         q0.push_back('{we: 1'b0, addr: 7'h03, data: 8'h00});
         q1.push_back('{we: 1'b0, addr: 7'h04, data: 8'h00});
         run_batch(1'b0);
      end
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 7'h10;
      seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         @(negedge clk);
         if (bus.mem_en) seen = 1;
      end
      check("rst_grant_seen", seen, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_mem_en", 32'(bus.mem_en), 0);
      check("async_rd_wr", 32'({bus.mem_read, bus.mem_write}), 0);
      check("async_ack_err", 32'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 0);
      bus.req1   = 1'b0;
      rr_m       = 1'b0;
      last_rd[0] = '0;
      last_rd[1] = '0;
      repeat (2) @(negedge clk);
      check("rst_mid_rdata0", 32'(bus.rdata0), 0);
      check("rst_mid_rdata1", 32'(bus.rdata1), 0);
      rst_n = 1'b1;
      q0.push_back('{we: 1'b0, addr: 7'h05, data: 8'h00});
      q1.push_back('{we: 1'b0, addr: 7'h10, data: 8'h00});
      run_batch(1'b0);
      idle(3);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
